// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal hold/shift/load register with an LSB-first serializer mode.
// Define ROTATE_EN to make all shifts rotate instead of taking sin_r/sin_l.
module univ_shift_reg #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             ser_start,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SER} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q, shr_d, shl_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;

`ifdef ROTATE_EN
    assign shr_d = {q_q[0], q_q[WIDTH-1:1]};
    assign shl_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`else
    assign shr_d = {sin_r, q_q[WIDTH-1:1]};
    assign shl_d = {q_q[WIDTH-2:0], sin_l};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= RST_VAL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (ser_start) begin
                    q_q     <= din;
                    cnt_q   <= CW'(WIDTH - 1);
                    busy_q  <= 1'b1;
                    state_q <= SER;
                end else begin
                    q_q <= mode == 2'b11 ? din : mode == 2'b01 ? shr_d : mode == 2'b10 ? shl_d : q_q;
                end
            end else if (cnt_q != '0) begin
                q_q   <= shr_d;
                cnt_q <= cnt_q - 1'b1;
            end else begin
                // last bit already on sout_r: hold q and close the run
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
            end
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: table vectors plus serializer sequences, checked through an expectation queue.
module tb_univ_shift_reg;
`ifdef ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] din = 8'h00;
    logic       sin_r = 1'b0, sin_l = 1'b0, ser_start = 1'b0;
    logic [7:0] q;
    logic       sout_r, sout_l, busy, done;

    typedef struct {
        logic       r;
        logic [1:0] m;
        logic [7:0] d;
        logic       sr, sl, st;
        logic [7:0] eq;
        logic       eb, ed;
    } vec_t;

    typedef struct {
        string      nm;
        logic [7:0] q;
        logic       b, d;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .mode(mode), .din(din), .sin_r(sin_r), .sin_l(sin_l),
        .ser_start(ser_start), .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nx(input logic [7:0] v, input logic s);
        return ROT ? {v[0], v[7:1]} : {s, v[7:1]};
    endfunction

    task automatic drive(input string nm, input logic r, input logic [1:0] m, input logic [7:0] d,
                         input logic sr, input logic sl, input logic st,
                         input logic [7:0] eq, input logic eb, input logic ed);
        @(negedge clk);
        rst = r; mode = m; din = d; sin_r = sr; sin_l = sl; ser_start = st;
        sb.push_back('{nm, eq, eb, ed});
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (q !== e.q || busy !== e.b || done !== e.d || sout_r !== e.q[0] || sout_l !== e.q[7]) begin
                n_bad++;
                $display("FAIL %s: q=%h busy=%b done=%b sout_r=%b sout_l=%b, expected q=%h busy=%b done=%b sout_r=%b sout_l=%b",
                         e.nm, q, busy, done, sout_r, sout_l, e.q, e.b, e.d, e.q[0], e.q[7]);
            end
        end
    end

    initial begin
        vec_t       tbl[14];
        logic [7:0] m;
        tbl[0]  = '{1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, ROT ? 8'h2D : 8'hAD, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'hB4, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, ROT ? 8'hC0 : 8'h40, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, ROT ? 8'h03 : 8'h02, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++)
            drive($sformatf("vec%0d", i), tbl[i].r, tbl[i].m, tbl[i].d, tbl[i].sr, tbl[i].sl, tbl[i].st,
                  tbl[i].eq, tbl[i].eb, tbl[i].ed);

        m = 8'hC3;
        drive("ser_start", 1'b0, 2'b00, 8'hC3, 1'b0, 1'b0, 1'b1, m, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            m = nx(m, 1'b0);
            drive($sformatf("ser_bit%0d", k), 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, m, 1'b1, 1'b0);
        end
        drive("ser_done", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, m, 1'b0, 1'b1);
        drive("restart_on_done", 1'b0, 2'b01, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);

        m = 8'h3C;
        for (int k = 1; k < 4; k++) begin
            m = nx(m, 1'b1);
            drive($sformatf("ignore_bit%0d", k), 1'b0, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b1, m, 1'b1, 1'b0);
        end
        drive("abort_rst", 1'b1, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            drive($sformatf("no_done%0d", k), 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
